dac_frame_sched: RTL and testbench
==================================

Name: dac_frame_sched

Overview:
- Sample-rate scheduler and two-requester arbiter in front of the serial DAC transmitter (Data_In / Rx_Listo / Sync interface).
- Accepts 12-bit samples from two equalizer outputs, A and B, each through a valid/ack handshake.
- On every sample-period tick, it sequences one DAC frame per channel, in round-robin order.
- Handles underrun and frame slip. Sits between the equalizer datapath and the DAC transmitter top level.

Parameters:
- TICK_DIV, 2268: Clk cycles per sample period (100 MHz / 44.1 kHz); legal range ≥ 64.
- DATA_W, 12: sample width.
- START_TIMEOUT, 16: max cycles from Dac_Rx_Listo to Sync falling before abort.

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Rst  in  1  asynchronous active-low reset.
- Smp_A  in  DATA_W  channel A sample.
- Vld_A  in  1  Smp_A valid.
- Ack_A  out  1  one-cycle pulse: Smp_A captured.
- Smp_B  in  DATA_W  channel B sample.
- Vld_B  in  1  Smp_B valid.
- Ack_B  out  1  one-cycle pulse: Smp_B captured.
- Dac_Data  out  DATA_W  word to transmitter Data_In.
- Dac_Rx_Listo  out  1  one-cycle load strobe to transmitter.
- Dac_Sel  out  1  channel of current frame (0=A, 1=B).
- Dac_Sync  in  1  transmitter Sync; low while a frame shifts.
- Clr_Err  in  1  clears sticky flags.
- Underrun  out  2  sticky per-channel underrun, bit0=A.
- Frame_Slip  out  1  sticky: tick arrived while previous frame set unfinished.
- Timeout_Err  out  1  sticky: Sync never fell after strobe.

Behaviour:
- Reset: every output 0; Dac_Data=0; internal holding registers=0; tick counter=0; RR pointer=A; state IDLE.
- Reset asserted mid-frame aborts immediately, with no trailing strobe.
- Holding register per channel, 1 deep:
  - When Vld_x=1 and the register is empty, capture Smp_x and pulse Ack_x on the same edge. The register is then full.
  - When full, Vld_x is ignored and Ack_x stays 0.
- Tick counter: counts 0..TICK_DIV-1, wraps, and raises an internal tick for one cycle on wrap. It free-runs through every state.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE, NEXT.
  - IDLE: on tick, set first=RR pointer, go to LOAD.
  - LOAD (1 cycle): drive Dac_Sel=current channel.
    - If the holding register is full, Dac_Data=register contents and the register empties.
    - Otherwise Dac_Data=last sent value for that channel, and Underrun[ch] is set.
    - Assert Dac_Rx_Listo, go to WAIT_START.
  - WAIT_START: when Dac_Sync=0, go to WAIT_DONE. If START_TIMEOUT cycles elapse first, set Timeout_Err and go to NEXT.
  - WAIT_DONE: when Dac_Sync=1, go to NEXT.
  - NEXT: if the second channel of this tick is not yet served, switch channel and go to LOAD. Otherwise toggle the RR pointer and go to IDLE.
- Dac_Data and Dac_Sel hold their value from LOAD until the next LOAD.
- Latency: Dac_Rx_Listo asserts 2 cycles after the tick edge (IDLE→LOAD registered).
- Simultaneous capture and LOAD on the same channel: LOAD takes the register contents as they were before that edge. The empty→capture transition is evaluated after the LOAD drain, so a sample presented in the LOAD cycle is captured and acked on that edge.
- Tick while FSM not in IDLE: set Frame_Slip. That tick is dropped, not queued.
- Tick and NEXT→IDLE on the same edge: the tick is not slipped; the FSM goes straight to LOAD.
- Clr_Err clears all sticky flags. A set event in the same cycle wins.

Optional Feature:
- Macro DAC_UNDERRUN_MIDSCALE_EN.
- Defined: an underrun frame sends midscale 2^(DATA_W-1) (0x800), i.e. silence, instead of the last sample.
- Undefined: the last sent sample is repeated.
- Underrun flag behaviour is identical either way.

Decomposition:
- Shared package: FSM state encoding, DATA_W default, TICK_DIV default, MIDSCALE constant.
- Sub-module dac_smp_hold: the 1-deep holding register with valid/ack capture, drain input and full flag. Instantiated twice.

Test Plan:
- Reset sanity: Rst low mid-WAIT_DONE → all outputs 0, state IDLE, no Dac_Rx_Listo for ≥ 3 cycles after release.
- Normal frame set:
  - Smp_A=0x123, Smp_B=0xABC preloaded; model Sync low 16 cycles after strobe.
  - Expect: strobe with Dac_Sel=0, Data=0x123, then strobe with Dac_Sel=1, Data=0xABC.
  - Next tick starts with B (RR toggled).
- Underrun: no new A sample before the tick → A frame resends 0x123 (0x800 with the macro), and Underrun=2'b01.
- Timeout: Dac_Sync held 1 → Timeout_Err set 16 cycles after strobe; FSM proceeds to channel B.
- Frame slip: TICK_DIV=64 with Sync low 40 cycles per frame → Frame_Slip set; Clr_Err clears it.
- Capture during LOAD: Vld_A asserted in the LOAD cycle of A → old value sent, new value captured, Ack_A pulses once.

Source files
------------

// File: rtl/dac_frame_sched_pkg.sv
// ============================================================================
// dac_frame_sched_pkg : shared defaults, midscale code and FSM state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package dac_frame_sched_pkg;

    localparam int DATA_W_DEF        = 12;
    localparam int TICK_DIV_DEF      = 2268;
    localparam int START_TIMEOUT_DEF = 16;

    localparam logic [DATA_W_DEF-1:0] MIDSCALE = 12'h800;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_NEXT       = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dac_smp_hold.sv
// ============================================================================
// dac_smp_hold : one-deep sample holding register with valid/ack capture
// Revision 1.0
// ============================================================================
`default_nettype none

module dac_smp_hold
    import dac_frame_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] smp,
    input  logic              vld,
    input  logic              drain,
    output logic              ack,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // A drain frees the slot on the same edge, so a waiting sample is taken then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
            ack  <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (drain) begin
                full <= 1'b0;
            end
            if (vld && (!full || drain)) begin
                data <= smp;
                full <= 1'b1;
                ack  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_frame_sched.sv
// ============================================================================
// dac_frame_sched : sample-rate tick, A/B round-robin DAC frame sequencing
// Optional macro DAC_UNDERRUN_MIDSCALE_EN: underrun frames send midscale. Rev 1.0
// ============================================================================
`default_nettype none

module dac_frame_sched
    import dac_frame_sched_pkg::*;
#(
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Smp_A,
    input  logic              Vld_A,
    output logic              Ack_A,
    input  logic [DATA_W-1:0] Smp_B,
    input  logic              Vld_B,
    output logic              Ack_B,
    output logic [DATA_W-1:0] Dac_Data,
    output logic              Dac_Rx_Listo,
    output logic              Dac_Sel,
    input  logic              Dac_Sync,
    input  logic              Clr_Err,
    output logic [1:0]        Underrun,
    output logic              Frame_Slip,
    output logic              Timeout_Err
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam int               TO_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(START_TIMEOUT - 1);

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [2:0]        state;
    logic              cur_ch;
    logic              second;
    logic              rr;
    logic [TO_W-1:0]   to_cnt;

    logic              full_a, full_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic [DATA_W-1:0] fill_a, fill_b;
    logic              load_a, load_b, drain_a, drain_b;
    logic [1:0]        urun_set;
    logic              slip_set, timeout_hit;
    logic [DATA_W-1:0] load_word;

    dac_smp_hold #(.DATA_W(DATA_W)) u_hold_a (
        .clk   (Clk),
        .rst_n (Rst),
        .smp   (Smp_A),
        .vld   (Vld_A),
        .drain (drain_a),
        .ack   (Ack_A),
        .full  (full_a),
        .data  (data_a)
    );

    dac_smp_hold #(.DATA_W(DATA_W)) u_hold_b (
        .clk   (Clk),
        .rst_n (Rst),
        .smp   (Smp_B),
        .vld   (Vld_B),
        .drain (drain_b),
        .ack   (Ack_B),
        .full  (full_b),
        .data  (data_b)
    );

`ifdef DAC_UNDERRUN_MIDSCALE_EN
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    assign fill_a = MID;
    assign fill_b = MID;
`else
    logic [DATA_W-1:0] last_a, last_b;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_a <= '0;
            last_b <= '0;
        end else begin
            if (drain_a) last_a <= data_a;
            if (drain_b) last_b <= data_b;
        end
    end

    assign fill_a = last_a;
    assign fill_b = last_b;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == CNT_MAX);
            tick_cnt <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        load_a      = (state == S_LOAD) && !cur_ch;
        load_b      = (state == S_LOAD) && cur_ch;
        drain_a     = load_a && full_a;
        drain_b     = load_b && full_b;
        urun_set    = {load_b && !full_b, load_a && !full_a};
        timeout_hit = (state == S_WAIT_START) && Dac_Sync && (to_cnt == TO_MAX);
        // A tick landing on the NEXT->IDLE edge starts the next set directly.
        slip_set    = tick && !((state == S_IDLE) || ((state == S_NEXT) && second));
        load_word   = '0;
        if (cur_ch) load_word = full_b ? data_b : fill_b;
        else        load_word = full_a ? data_a : fill_a;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= S_IDLE;
            cur_ch       <= 1'b0;
            second       <= 1'b0;
            rr           <= 1'b0;
            to_cnt       <= '0;
            Dac_Data     <= '0;
            Dac_Sel      <= 1'b0;
            Dac_Rx_Listo <= 1'b0;
        end else begin
            Dac_Rx_Listo <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        cur_ch <= rr;
                        second <= 1'b0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    Dac_Data     <= load_word;
                    Dac_Sel      <= cur_ch;
                    Dac_Rx_Listo <= 1'b1;
                    to_cnt       <= '0;
                    state        <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (!Dac_Sync)           state  <= S_WAIT_DONE;
                    else if (to_cnt == TO_MAX) state <= S_NEXT;
                    else                     to_cnt <= to_cnt + TO_W'(1);
                end
                S_WAIT_DONE: begin
                    if (Dac_Sync) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (!second) begin
                        cur_ch <= ~cur_ch;
                        second <= 1'b1;
                        state  <= S_LOAD;
                    end else begin
                        rr <= ~rr;
                        if (tick) begin
                            cur_ch <= ~rr;
                            second <= 1'b0;
                            state  <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the clearing cycle survives the clear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Underrun    <= 2'b00;
            Frame_Slip  <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            Underrun    <= (Clr_Err ? 2'b00 : Underrun) | urun_set;
            Frame_Slip  <= (Clr_Err ? 1'b0 : Frame_Slip) | slip_set;
            Timeout_Err <= (Clr_Err ? 1'b0 : Timeout_Err) | timeout_hit;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dac_frame_sched.sv
// ============================================================================
// tb_dac_frame_sched : directed scoreboard bench for dac_frame_sched
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dac_frame_sched;

    localparam int DW = 12;
    localparam int TD = 64;

    typedef struct packed {
        logic          sel;
        logic [DW-1:0] data;
    } frame_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [DW-1:0] Smp_A = '0, Smp_B = '0;
    logic          Vld_A = 1'b0, Vld_B = 1'b0;
    logic          Ack_A, Ack_B;
    logic [DW-1:0] Dac_Data;
    logic          Dac_Rx_Listo, Dac_Sel;
    logic          Dac_Sync = 1'b1;
    logic          Clr_Err = 1'b0;
    logic [1:0]    Underrun;
    logic          Frame_Slip, Timeout_Err;

    int checks = 0;
    int failures = 0;
    int sync_low = 16;
    bit sync_never = 1'b0;
    int ack_a_cnt = 0;

    frame_t        exp_q[$];
    frame_t        mon_f;
    logic [DW-1:0] m_hold[2];
    logic          m_full[2];
    logic [DW-1:0] m_last[2];
    logic          m_rr;

    always #5 Clk = ~Clk;

    dac_frame_sched #(.TICK_DIV(TD), .DATA_W(DW), .START_TIMEOUT(16)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Smp_A        (Smp_A),
        .Vld_A        (Vld_A),
        .Ack_A        (Ack_A),
        .Smp_B        (Smp_B),
        .Vld_B        (Vld_B),
        .Ack_B        (Ack_B),
        .Dac_Data     (Dac_Data),
        .Dac_Rx_Listo (Dac_Rx_Listo),
        .Dac_Sel      (Dac_Sel),
        .Dac_Sync     (Dac_Sync),
        .Clr_Err      (Clr_Err),
        .Underrun     (Underrun),
        .Frame_Slip   (Frame_Slip),
        .Timeout_Err  (Timeout_Err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill_val(input logic ch);
`ifdef DAC_UNDERRUN_MIDSCALE_EN
        return (ch === 1'bx) ? 12'h800 : 12'h800;
`else
        return m_last[ch];
`endif
    endfunction

    // Transmitter model: Sync drops two cycles after the strobe for sync_low cycles.
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst && Dac_Rx_Listo === 1'b1 && !sync_never) begin
                repeat (2) @(negedge Clk);
                Dac_Sync = 1'b0;
                repeat (sync_low) @(negedge Clk);
                Dac_Sync = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (Rst && Dac_Rx_Listo !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {31'd0, Dac_Rx_Listo}, 32'd0);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_sel", {31'd0, Dac_Sel}, {31'd0, mon_f.sel});
                    check("frame_data", {20'd0, Dac_Data}, {20'd0, mon_f.data});
                end
            end
            if (Ack_A === 1'b1) ack_a_cnt++;
        end
    end

    task automatic load_smp(input logic ch, input logic [DW-1:0] v);
        logic got;
        @(negedge Clk);
        if (ch) begin Smp_B = v; Vld_B = 1'b1; end
        else    begin Smp_A = v; Vld_A = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge Clk);
            got = ch ? Ack_B : Ack_A;
        end
        if (ch) Vld_B = 1'b0; else Vld_A = 1'b0;
        check(ch ? "ack_b" : "ack_a", {31'd0, got}, 32'd1);
        m_hold[ch] = v;
        m_full[ch] = 1'b1;
    endtask

    task automatic push_set();
        logic   ch;
        frame_t f;
        ch = m_rr;
        for (int k = 0; k < 2; k++) begin
            f.sel = ch;
            if (m_full[ch]) begin
                f.data     = m_hold[ch];
                m_last[ch] = m_hold[ch];
                m_full[ch] = 1'b0;
            end else begin
                f.data = fill_val(ch);
            end
            exp_q.push_back(f);
            ch = ~ch;
        end
        m_rr = ~m_rr;
    endtask

    task automatic wait_set_done(input int extra);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("set_done_in_time", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (extra) @(negedge Clk);
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        @(negedge Clk);
        while (Dac_Rx_Listo !== 1'b1 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("strobe_seen", {31'd0, Dac_Rx_Listo}, 32'd1);
    endtask

    task automatic clear_errors();
        @(negedge Clk);
        Clr_Err = 1'b1;
        @(negedge Clk);
        Clr_Err = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack_a"}, {31'd0, Ack_A}, 32'd0);
        check({tag, "_ack_b"}, {31'd0, Ack_B}, 32'd0);
        check({tag, "_data"}, {20'd0, Dac_Data}, 32'd0);
        check({tag, "_listo"}, {31'd0, Dac_Rx_Listo}, 32'd0);
        check({tag, "_sel"}, {31'd0, Dac_Sel}, 32'd0);
        check({tag, "_underrun"}, {30'd0, Underrun}, 32'd0);
        check({tag, "_slip"}, {31'd0, Frame_Slip}, 32'd0);
        check({tag, "_timeout"}, {31'd0, Timeout_Err}, 32'd0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_hold[c] = '0;
            m_full[c] = 1'b0;
            m_last[c] = '0;
        end
        m_rr = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        check_idle_outputs("reset");
        Rst = 1'b1;

        // Normal set, A first.
        load_smp(1'b0, 12'h123);
        load_smp(1'b1, 12'hABC);
        push_set();
        wait_set_done(25);
        check("normal_underrun", {30'd0, Underrun}, 32'd0);
        check("normal_timeout", {31'd0, Timeout_Err}, 32'd0);

        // Round robin toggled: B first.
        load_smp(1'b0, 12'h456);
        load_smp(1'b1, 12'h789);
        push_set();
        wait_set_done(25);

        // Underrun on A only.
        load_smp(1'b1, 12'h5A5);
        push_set();
        wait_set_done(25);
        check("underrun_a", {30'd0, Underrun}, 32'd1);
        clear_errors();
        check("underrun_clr", {30'd0, Underrun}, 32'd0);

        // Timeout: Sync never falls, flag exactly 16 cycles after strobe.
        sync_never = 1'b1;
        load_smp(1'b0, 12'h0F0);
        load_smp(1'b1, 12'h00F);
        push_set();
        wait_strobe();
        repeat (15) @(negedge Clk);
        check("timeout_early", {31'd0, Timeout_Err}, 32'd0);
        @(negedge Clk);
        check("timeout_set", {31'd0, Timeout_Err}, 32'd1);
        wait_set_done(25);
        check("timeout_sticky", {31'd0, Timeout_Err}, 32'd1);
        clear_errors();
        check("timeout_clr", {31'd0, Timeout_Err}, 32'd0);
        sync_never = 1'b0;

        // New A sample held valid while A is full: taken on the LOAD edge.
        load_smp(1'b0, 12'h111);
        load_smp(1'b1, 12'h222);
        push_set();
        @(negedge Clk);
        ack_a_cnt = 0;
        Smp_A = 12'h333;
        Vld_A = 1'b1;
        for (int i = 0; i < 300 && Ack_A !== 1'b1; i++) @(negedge Clk);
        check("load_ack_with_strobe", {31'd0, Dac_Rx_Listo}, 32'd1);
        check("load_ack_sel", {31'd0, Dac_Sel}, 32'd0);
        Vld_A = 1'b0;
        m_hold[0] = 12'h333;
        m_full[0] = 1'b1;
        wait_set_done(25);
        check("load_ack_count", ack_a_cnt, 32'd1);

        load_smp(1'b1, 12'h444);
        push_set();
        wait_set_done(25);
        check("pre_slip", {31'd0, Frame_Slip}, 32'd0);
        check("pre_slip_underrun", {30'd0, Underrun}, 32'd0);

        // Long frames overrun the sample period.
        sync_low = 40;
        load_smp(1'b0, 12'h7E7);
        load_smp(1'b1, 12'h818);
        push_set();
        wait_set_done(25);
        sync_low = 16;
        check("slip_set", {31'd0, Frame_Slip}, 32'd1);
        clear_errors();
        check("slip_clr", {31'd0, Frame_Slip}, 32'd0);

        // Dropped tick did not toggle the pointer; both channels underrun.
        push_set();
        wait_set_done(25);
        check("underrun_both", {30'd0, Underrun}, 32'd3);
        check("slip_once", {31'd0, Frame_Slip}, 32'd0);
        clear_errors();

        // Reset while the B frame is shifting.
        load_smp(1'b0, 12'h9C3);
        load_smp(1'b1, 12'h3C9);
        push_set();
        wait_set_done(0);
        repeat (8) @(negedge Clk);
        check("pre_reset_sel", {31'd0, Dac_Sel}, 32'd1);
        Rst = 1'b0;
        @(negedge Clk);
        check_idle_outputs("midreset");
        model_reset();
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("post_reset_listo", {31'd0, Dac_Rx_Listo}, 32'd0);
        end

        // Cleared holding registers and pointer back at A.
        push_set();
        wait_set_done(5);
        check("post_reset_underrun", {30'd0, Underrun}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
